// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small byte FIFO; queued frames go out back-to-back.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] data_in,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx,
  output logic       done,
  output logic       led_tx
);

  // state  | meaning
  // IDLE   | line high, waiting for a queued byte
  // START  | start bit (0)
  // DATA   | eight data bits, LSB first
  // PARITY | even parity bit (UART_TX_PARITY_EN builds only)
  // STOP   | stop bit (1); pops the next byte at terminal count

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int LAST_I = CLKS_PER_BIT - 1;
  localparam logic [CW-1:0] LAST  = LAST_I[CW-1:0];
  localparam logic [PW:0]   DEPTH = FIFO_DEPTH[PW:0];

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          bit_end;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign head    = mem[rd_ptr];
  assign bit_end = (cnt == LAST);
  assign push    = wr && !full && !clr;
  // The FSM pops either from IDLE or at the end of a stop bit to chain frames.
  assign pop     = !clr && (count != '0) &&
                   ((state == IDLE) || ((state == STOP) && bit_end));
  assign led_tx  = busy;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= head;
`ifdef UART_TX_PARITY_EN
            parity <= ^head;
`endif
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= START;
          end
        end

        START: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            done <= 1'b1;
            if (pop) begin
              shreg <= head;
`ifdef UART_TX_PARITY_EN
              parity <= ^head;
`endif
              tx    <= 1'b0;
              cnt   <= '0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor decodes frames and pops expected bytes.
// Frame length follows UART_TX_PARITY_EN when the design is built with it.
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       clr;
  logic       wr;
  logic [7:0] data_in;
  logic       full, empty, busy, tx, done, led_tx;

  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  int         starts [$];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .clr(clr), .data_in(data_in), .wr(wr),
    .full(full), .empty(empty), .busy(busy), .tx(tx), .done(done), .led_tx(led_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait n falling edges; remember whether clr was seen so an aborted frame is ignored.
  task automatic step(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (clr === 1'b1) ab = 1'b1;
    end
  endtask

  task automatic rx_frame();
    logic       ab;
    logic [7:0] b;
    logic [7:0] e;
    logic       sb, pb, stb, bz, d_pre, d_end;
    ab = 1'b0;
    b  = '0;
    pb = 1'b0;
    starts.push_back(cyc);
    step(CPB / 2, ab);
    sb = tx;
    bz = busy;
    for (int i = 0; i < 8; i++) begin
      step(CPB, ab);
      b[i] = tx;
      bz   = bz & busy;
    end
`ifdef UART_TX_PARITY_EN
    step(CPB, ab);
    pb = tx;
    bz = bz & busy;
`endif
    step(CPB, ab);
    stb = tx;
    bz  = bz & busy;
    step(CPB / 2 - 1, ab);
    d_pre = done;
    step(1, ab);
    d_end = done;
    if (!ab) begin
      check_eq("rx_frame_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("rx_data", b, e);
`ifdef UART_TX_PARITY_EN
        check_eq("rx_parity", pb, ^e);
`endif
      end
      check_eq("rx_start_bit", sb, 0);
      check_eq("rx_stop_bit", stb, 1);
      check_eq("rx_busy_in_frame", bz, 1);
      check_eq("rx_done_before_end", d_pre, 0);
      check_eq("rx_done_at_end", d_end, 1);
    end
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      while (tx === 1'b0 && clr === 1'b0) rx_frame();
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20 * FRAME) begin
      tick();
      n++;
    end
    tick();
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0, n0, blen, n, bad_tx, bad_busy, bad_done, bad_full;
    clr = 1'b1;
    wr = 1'b0;
    data_in = '0;
    repeat (3) tick();
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_led", led_tx, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_empty", empty, 1);
    clr = 1'b0;

    // idle line
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_full = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if (full !== 1'b0) bad_full++;
    end
    check_eq("idle_tx_low", bad_tx, 0);
    check_eq("idle_busy", bad_busy, 0);
    check_eq("idle_done", bad_done, 0);
    check_eq("idle_full", bad_full, 0);

    // single byte
    tick();
    d0 = done_cnt;
    wr = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr = 1'b0;
    check_eq("wr_empty_fall", empty, 0);
    check_eq("wr_tx_still_idle", tx, 1);
    check_eq("wr_busy_still_low", busy, 0);
    tick();
    check_eq("start_tx_low", tx, 0);
    check_eq("start_busy", busy, 1);
    check_eq("start_led", led_tx, 1);
    blen = 0;
    while (busy === 1'b1 && blen < 10 * FRAME) begin
      tick();
      blen++;
    end
    check_eq("single_busy_len", blen, FRAME);
    check_eq("single_done_at_busy_fall", done, 1);
    check_eq("single_empty_after", empty, 1);
    drain("single");
    check_eq("single_done_count", done_cnt - d0, 1);

    // back-to-back frames
    d0 = done_cnt;
    n0 = starts.size();
    wr = 1'b1; data_in = 8'h00; exp_q.push_back(8'h00);
    tick();
    data_in = 8'hFF; exp_q.push_back(8'hFF);
    tick();
    wr = 1'b0;
    tick();
    blen = 1;
    while (busy === 1'b1 && blen < 10 * FRAME) begin
      tick();
      blen++;
    end
    check_eq("b2b_busy_len", blen, 2 * FRAME);
    drain("b2b");
    check_eq("b2b_done_count", done_cnt - d0, 2);
    check_eq("b2b_frame_count", starts.size() - n0, 2);
    if (starts.size() - n0 >= 2)
      check_eq("b2b_start_spacing", starts[n0 + 1] - starts[n0], FRAME);

    // odd-parity-weight byte
    d0 = done_cnt;
    wr = 1'b1; data_in = 8'h07; exp_q.push_back(8'h07);
    tick();
    wr = 1'b0;
    drain("byte07");
    check_eq("byte07_done_count", done_cnt - d0, 1);

    // FIFO full: six writes, the sixth is dropped
    d0 = done_cnt;
    n0 = starts.size();
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1;
      data_in = 8'h10 + 8'(i);
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      tick();
      if (i == 3) check_eq("full_after_4th", full, 0);
      if (i == 4) check_eq("full_after_5th", full, 1);
      if (i == 5) check_eq("full_after_6th", full, 1);
    end
    wr = 1'b0;
    n = 0;
    while (full === 1'b1 && n < 10 * FRAME) begin
      tick();
      n++;
    end
    check_eq("full_fall", full, 0);
    check_eq("full_fall_with_done", done, 1);
    drain("fifo_full");
    check_eq("full_done_count", done_cnt - d0, 5);
    check_eq("full_frame_count", starts.size() - n0, 5);

    // reset mid-frame
    d0 = done_cnt;
    n0 = starts.size();
    wr = 1'b1; data_in = 8'h3C;
    tick();
    data_in = 8'hC3;
    tick();
    data_in = 8'h5A;
    tick();
    wr = 1'b0;
    check_eq("clr_frame_started", tx, 0);
    repeat (13) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_tx", tx, 1);
    check_eq("clr_busy", busy, 0);
    check_eq("clr_empty", empty, 1);
    check_eq("clr_done", done, 0);
    check_eq("clr_full", full, 0);
    bad_tx = 0; bad_done = 0;
    repeat (6 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (done !== 1'b0) bad_done++;
    end
    check_eq("clr_no_more_frames", bad_tx, 0);
    check_eq("clr_no_done", bad_done, 0);
    check_eq("clr_done_count", done_cnt - d0, 0);
    check_eq("clr_frame_count", starts.size() - n0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
